// File: rtl/melody_sequencer.sv
// melody_sequencer
// Alarm-melody sequencer feeding the square-wave tone generator. A start pulse
// steps through a fixed 8-entry note table. Each entry drives a half-period
// divider and tone enable for its duration, followed by a silent gap. The
// melody plays `repeats` passes, or loops until stop when repeats is 0.
//
// Parameters
//   TICK_DIV  clk cycles per 1 ms tick
//   GAP_MS    silent gap after every table entry, in ms ticks (>= 1)
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   start        in   1   1-cycle pulse; begins playback when idle
//   stop         in   1   abort playback (level or pulse)
//   repeats      in   4   passes to play, sampled on accepted start; 0 = loop
//   clk_divider  out  16  half-period reload value for the tone generator
//   tone_en      out  1   tone audible
//   busy         out  1   high from accepted start until done or stop
//   note_idx     out  3   table entry currently playing
//   done         out  1   1-cycle pulse when all passes complete normally
module melody_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  repeats,
  output logic [15:0] clk_divider,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  note_idx,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]    GAP_LAST   = 10'(GAP_MS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [9:0]      ms_q, ms_d;
  logic [3:0]      pass_q, pass_d;
  logic [2:0]      idx_d;
  logic [15:0]     div_d;
  logic            tone_d, busy_d, done_d;
  logic            timing, ms_tick;

  // Divider of each table entry; 0 marks a REST.
  function automatic logic [15:0] entry_div(input logic [2:0] idx);
    case (idx)
      3'd0:    entry_div = 16'd47777;
      3'd1:    entry_div = 16'd37921;
      3'd2:    entry_div = 16'd31887;
      3'd3:    entry_div = 16'd23888;
      3'd4:    entry_div = 16'd0;
      3'd5:    entry_div = 16'd31887;
      3'd6:    entry_div = 16'd23888;
      default: entry_div = 16'd0;
    endcase
  endfunction

  // Duration of each table entry in ms.
  function automatic logic [9:0] entry_dur(input logic [2:0] idx);
    case (idx)
      3'd0:    entry_dur = 10'd150;
      3'd1:    entry_dur = 10'd150;
      3'd2:    entry_dur = 10'd150;
      3'd3:    entry_dur = 10'd300;
      3'd4:    entry_dur = 10'd100;
      3'd5:    entry_dur = 10'd150;
      3'd6:    entry_dur = 10'd450;
      default: entry_dur = 10'd500;
    endcase
  endfunction

  // Next-state logic. Outputs are computed from the next state so that they
  // can be registered alongside it and line up with the state they describe.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    idx_d   = note_idx;
    timing  = (state_q == PLAY) || (state_q == GAP);
    ms_tick = timing && (presc_q == PRESC_LAST);
    presc_d = (!timing || ms_tick) ? '0 : presc_q + 1'b1;
    ms_d    = !timing ? 10'd0 : (ms_tick ? ms_q + 10'd1 : ms_q);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = PLAY;
          pass_d  = repeats;
          idx_d   = 3'd0;
        end
      end
      PLAY: begin
        if (stop)
          state_d = IDLE;
        else if (ms_tick && (ms_q == entry_dur(note_idx) - 10'd1))
          state_d = GAP;
      end
      GAP: begin
        if (stop)
          state_d = IDLE;
        else if (ms_tick && (ms_q == GAP_LAST)) begin
          if (note_idx != 3'd7) begin
            idx_d   = note_idx + 3'd1;
            state_d = PLAY;
          end else if (pass_q != 4'd1) begin
            // A pass count of 0 means loop forever, so it never decrements.
            if (pass_q != 4'd0)
              pass_d = pass_q - 4'd1;
            idx_d   = 3'd0;
            state_d = PLAY;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry restarts the ms timebase so spans are exact multiples.
    if (state_d != state_q) begin
      presc_d = '0;
      ms_d    = 10'd0;
    end

    busy_d = (state_d == PLAY) || (state_d == GAP);
    done_d = (state_d == DONE);
    if (!busy_d)
      idx_d = 3'd0;
    tone_d = (state_d == PLAY) && (entry_div(idx_d) != 16'd0);
    case (state_d)
      PLAY:    div_d = entry_div(idx_d);
      GAP:     div_d = clk_divider;
      default: div_d = 16'd0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      ms_q        <= 10'd0;
      pass_q      <= 4'd0;
      note_idx    <= 3'd0;
      clk_divider <= 16'd0;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      pass_q      <= pass_d;
      note_idx    <= idx_d;
      clk_divider <= div_d;
      tone_en     <= tone_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
// Drives melody_sequencer with directed scenarios and random start/stop/reset
// traffic, comparing every cycle against a timeline model of the melody.
module tb_melody_sequencer;

  localparam int T        = 4;
  localparam int GAP      = 2;
  localparam int PASS_LEN = (1950 + 8 * GAP) * T;

  typedef struct packed {
    logic [15:0] div;
    logic        tone;
    logic        busy;
    logic [2:0]  idx;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [3:0]  repeats;
  logic [15:0] clk_divider;
  logic        tone_en, busy, done;
  logic [2:0]  note_idx;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int done_cnt = 0;
  int cur = 0;
  bit chk_en = 1'b0;

  int tab_div [8] = '{47777, 37921, 31887, 23888, 0, 31887, 23888, 0};
  int tab_dur [8] = '{150, 150, 150, 300, 100, 150, 450, 500};

  bit   m_active = 1'b0;
  int   m_start = 0;
  int   m_rep = 0;
  exp_t exp_v = '0;

  melody_sequencer #(.TICK_DIV(T), .GAP_MS(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .repeats(repeats),
    .clk_divider(clk_divider), .tone_en(tone_en), .busy(busy),
    .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  // Expected outputs e cycles into a playback (e = 1 is the first busy cycle).
  function automatic exp_t model_at(int e, int rep);
    exp_t x;
    int   r;
    x = '0;
    if (rep != 0 && e == rep * PASS_LEN + 1) begin
      x.done = 1'b1;
      return x;
    end
    r = (e - 1) % PASS_LEN;
    x.busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (r < tab_dur[i] * T) begin
        x.idx  = 3'(i);
        x.div  = 16'(tab_div[i]);
        x.tone = (tab_div[i] != 0);
        return x;
      end
      r -= tab_dur[i] * T;
      if (r < GAP * T) begin
        x.idx = 3'(i);
        x.div = 16'(tab_div[i]);
        return x;
      end
      r -= GAP * T;
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Reference model: reacts to the inputs seen at each edge.
  always @(posedge clk) begin
    edge_cnt++;
    if (reset)
      m_active = 1'b0;
    else if (exp_v.busy && stop)
      m_active = 1'b0;
    else if (!exp_v.busy && !exp_v.done && start && !stop) begin
      m_active = 1'b1;
      m_start  = edge_cnt;
      m_rep    = int'(repeats);
    end
    if (m_active && m_rep != 0 && (edge_cnt - m_start + 1) > m_rep * PASS_LEN + 1)
      m_active = 1'b0;
    exp_v = m_active ? model_at(edge_cnt - m_start + 1, m_rep) : '0;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("clk_divider", {16'd0, clk_divider}, {16'd0, exp_v.div});
      checkOutput("tone_en", {31'd0, tone_en}, {31'd0, exp_v.tone});
      checkOutput("busy", {31'd0, busy}, {31'd0, exp_v.busy});
      checkOutput("note_idx", {29'd0, note_idx}, {29'd0, exp_v.idx});
      checkOutput("done", {31'd0, done}, {31'd0, exp_v.done});
      if (done === 1'b1)
        done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goTo(input int target);
    tick(target - cur);
    cur = target;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic [3:0] r);
    start   = s;
    stop    = p;
    repeats = r;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    cur   = 1;
  endtask

  task automatic checkAll(input string name, input int d, input int t, input int b, input int ix);
    checkOutput({name, "_div"}, {16'd0, clk_divider}, 32'(d));
    checkOutput({name, "_tone"}, {31'd0, tone_en}, 32'(t));
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'(b));
    checkOutput({name, "_idx"}, {29'd0, note_idx}, 32'(ix));
  endtask

  initial begin
    exp_t mx;
    reset = 1'b1; start = 1'b0; stop = 1'b0; repeats = 4'd0;
    @(posedge clk);
    chk_en = 1'b1;

    // Pin the model with hand-computed timeline points.
    mx = model_at(601, 1);
    checkOutput("model_e601_tone", {31'd0, mx.tone}, 32'd0);
    mx = model_at(609, 1);
    checkOutput("model_e609_div", {16'd0, mx.div}, 32'd37921);
    mx = model_at(3033, 1);
    checkOutput("model_e3033_idx", {29'd0, mx.idx}, 32'd4);
    mx = model_at(PASS_LEN + 1, 1);
    checkOutput("model_done", {31'd0, mx.done}, 32'd1);

    // Reset held, then idle with no start.
    repeat (5) @(negedge clk);
    reset = 1'b0;
    tick(20);
    checkAll("idle", 0, 0, 0, 0);
    checkOutput("idle_done", {31'd0, done}, 32'd0);

    // Single pass with literal timeline points; start during DONE is ignored.
    done_cnt = 0;
    applyStimulus(1'b1, 1'b0, 4'd1);
    checkAll("s2_n1", 47777, 1, 1, 0);
    goTo(600);  checkAll("s2_n600", 47777, 1, 1, 0);
    goTo(601);  checkAll("s2_n601", 47777, 0, 1, 0);
    goTo(608);  checkAll("s2_n608", 47777, 0, 1, 0);
    goTo(609);  checkAll("s2_n609", 37921, 1, 1, 1);
    goTo(3033); checkAll("s2_rest4", 0, 0, 1, 4);
    goTo(3441); checkAll("s2_n3441", 31887, 1, 1, 5);
    goTo(5857); checkAll("s2_rest7", 0, 0, 1, 7);
    goTo(7864); checkAll("s2_last", 0, 0, 1, 7);
    goTo(7865);
    checkAll("s2_done", 0, 0, 0, 0);
    checkOutput("s2_done_pulse", {31'd0, done}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'd1);
    checkAll("s2_after", 0, 0, 0, 0);
    checkOutput("s2_done_once", 32'(done_cnt), 32'd1);
    tick(3);

    // Two passes: one wrap 7 -> 0, one done pulse.
    done_cnt = 0;
    applyStimulus(1'b1, 1'b0, 4'd2);
    goTo(7864);  checkAll("s3_pre_wrap", 0, 0, 1, 7);
    goTo(7865);  checkAll("s3_wrap", 47777, 1, 1, 0);
    goTo(15728); checkAll("s3_last", 0, 0, 1, 7);
    goTo(15729); checkOutput("s3_done_pulse", {31'd0, done}, 32'd1);
    goTo(15731);
    checkOutput("s3_done_once", 32'(done_cnt), 32'd1);

    // Loop forever, three passes, then stop.
    done_cnt = 0;
    applyStimulus(1'b1, 1'b0, 4'd0);
    goTo(3 * PASS_LEN + 100); checkAll("s5_loop", 47777, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkAll("s5_stopped", 0, 0, 0, 0);
    tick(5);
    checkOutput("s5_no_done", 32'(done_cnt), 32'd0);

    // Start while busy is ignored; stop+start in idle stays idle.
    applyStimulus(1'b1, 1'b0, 4'd1);
    tick(100);
    applyStimulus(1'b1, 1'b0, 4'd9);
    checkAll("s6_ignored", 47777, 1, 1, 0);
    tick(50);
    applyStimulus(1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b1, 4'd3);
    checkAll("s6_stop_wins", 0, 0, 0, 0);

    // Reset in the middle of PLAY.
    applyStimulus(1'b1, 1'b0, 4'd1);
    tick(30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAll("s6_reset", 0, 0, 0, 0);
    tick(5);

    // Random start/stop/reset traffic checked by the model.
    for (int i = 0; i < 6000; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, 299) == 0);
      reset   = ($urandom_range(0, 1999) == 0);
      repeats = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
